// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request and data-memory bus bundle for the load/store unit
//
// Purpose: groups the EX/MEM request handshake and the word-addressed data
// memory port so the unit and its environment connect through one port.
// Ports (signals):
//   req_valid, req_ready, req_write, req_funct3, req_addr, req_wdata  - request channel
//   mem_en, mem_we, mem_addr, mem_wdata, mem_rdata                    - data memory port
// Modports:
//   slave  - the load/store unit (consumes requests, drives memory)
//   master - the pipeline plus memory (issues requests, returns read data)

interface load_store_unit_if #(
    parameter int DATA_ADDRESS_WIDTH = 6,
    parameter int CPU_DATA_WIDTH     = 32
);
    logic                          req_valid;
    logic                          req_ready;
    logic                          req_write;
    logic [2:0]                    req_funct3;
    logic [CPU_DATA_WIDTH-1:0]     req_addr;
    logic [CPU_DATA_WIDTH-1:0]     req_wdata;

    logic                          mem_en;
    logic [3:0]                    mem_we;
    logic [DATA_ADDRESS_WIDTH-1:0] mem_addr;
    logic [CPU_DATA_WIDTH-1:0]     mem_wdata;
    logic [CPU_DATA_WIDTH-1:0]     mem_rdata;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I MEM-stage load/store unit
//
// Purpose: turns LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses with
// byte write masks, extends load data, stalls the pipeline while a
// synchronous-read load is in flight, and flags misaligned / faulting requests.
// Ports:
//   clk          - clock, rising edge
//   rst_n        - asynchronous active-low reset
//   bus          - request channel + data memory port (slave view)
//   flush        - squash an in-flight load / block acceptance
//   stall        - hold IF..EX/MEM this cycle
//   load_valid   - one-cycle pulse, load_data valid
//   load_data    - extended load result (registered)
//   misaligned   - one-cycle pulse, misaligned request dropped
//   access_fault - one-cycle pulse, out-of-range address or illegal funct3

module load_store_unit #(
    parameter int DATA_ADDRESS_WIDTH = 6,
    parameter int CPU_DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    load_store_unit_if.slave          bus,
    input  logic                      flush,
    output logic                      stall,
    output logic                      load_valid,
    output logic [CPU_DATA_WIDTH-1:0] load_data,
    output logic                      misaligned,
    output logic                      access_fault
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    state_t                    state;
    logic                      load_valid_q;
    logic [1:0]                lane_q;
    logic [2:0]                funct3_q;

    logic                      accept;
    logic                      range_fault;
    logic                      funct3_illegal;
    logic                      fault;
    logic                      misaligned_raw;
    logic                      issue;
    logic [1:0]                size;
    logic [CPU_DATA_WIDTH-1:0] shifted;
    logic [CPU_DATA_WIDTH-1:0] extended;

    assign size = bus.req_funct3[1:0];

    // Reset gates acceptance so no access leaks out while rst_n is held low.
    assign accept = bus.req_valid && (state == IDLE) && !flush && rst_n;

    assign range_fault = |bus.req_addr[CPU_DATA_WIDTH-1:DATA_ADDRESS_WIDTH+2];

    // Stores only have sizes 000/001/010; loads add the unsigned 100/101.
    always_comb begin
        funct3_illegal = 1'b0;
        if (bus.req_write) begin
            funct3_illegal = bus.req_funct3[2] || (bus.req_funct3 == 3'b011);
        end else begin
            funct3_illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                             (bus.req_funct3 == 3'b111);
        end
    end

    assign fault          = range_fault || funct3_illegal;
    assign misaligned_raw = ((size == 2'b01) && bus.req_addr[0]) ||
                            ((size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    assign issue          = accept && !fault && !misaligned_raw;

    assign bus.req_ready = (state == IDLE);
    assign bus.mem_en    = issue;
    assign bus.mem_addr  = bus.req_addr[DATA_ADDRESS_WIDTH+1:2];

    always_comb begin
        bus.mem_we    = 4'b0000;
        bus.mem_wdata = bus.req_wdata;
        case (size)
            2'b00: begin
                bus.mem_wdata = {4{bus.req_wdata[7:0]}};
                if (issue && bus.req_write) begin
                    bus.mem_we = 4'b0001 << bus.req_addr[1:0];
                end
            end
            2'b01: begin
                bus.mem_wdata = {2{bus.req_wdata[15:0]}};
                if (issue && bus.req_write) begin
                    bus.mem_we = 4'b0011 << bus.req_addr[1:0];
                end
            end
            default: begin
                if (issue && bus.req_write) begin
                    bus.mem_we = 4'b1111;
                end
            end
        endcase
    end

    // The pipeline is held in the accept cycle of a load and in RD_WAIT;
    // a flush releases it at once because the result is being discarded.
    assign stall = (issue && !bus.req_write) || ((state == RD_WAIT) && !flush);

    // Bring the addressed lane down to bit 0; halves only ever sit at lane 0 or 2.
    assign shifted = bus.mem_rdata >> {lane_q, 3'b000};

    always_comb begin
        extended = bus.mem_rdata;
        case (funct3_q)
            3'b000:  extended = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  extended = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  extended = {24'd0, shifted[7:0]};
            3'b101:  extended = {16'd0, shifted[15:0]};
            default: extended = bus.mem_rdata;
        endcase
    end

    // A flush arriving in RESP still squashes the pulse being presented.
    assign load_valid = load_valid_q && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            load_valid_q <= 1'b0;
            load_data    <= '0;
            misaligned   <= 1'b0;
            access_fault <= 1'b0;
            lane_q       <= 2'b00;
            funct3_q     <= 3'b000;
        end else begin
            misaligned   <= accept && !fault && misaligned_raw;
            access_fault <= accept && fault;
            load_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue && !bus.req_write) begin
                        lane_q   <= bus.req_addr[1:0];
                        funct3_q <= bus.req_funct3;
                        state    <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        load_data    <= extended;
                        load_valid_q <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit

module tb_load_store_unit;
    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        stall;
    logic        load_valid;
    logic [31:0] load_data;
    logic        misaligned;
    logic        access_fault;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [31:0] mem_model [64];

    load_store_unit_if #(.DATA_ADDRESS_WIDTH(6), .CPU_DATA_WIDTH(32)) bus ();

    load_store_unit #(.DATA_ADDRESS_WIDTH(6), .CPU_DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .flush        (flush),
        .stall        (stall),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .misaligned   (misaligned),
        .access_fault (access_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.mem_we[i]) begin
                    mem_model[bus.mem_addr][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
                end
            end
            if (bus.mem_we == 4'b0000) begin
                bus.mem_rdata <= mem_model[bus.mem_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        drive(1'b1, f3, addr, wdata);
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic load_check(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] exp);
        drive(1'b0, f3, addr, 32'd0);
        #1;
        check({tag, "_stall_n"}, stall, 1'b1);
        tick();
        bus.req_valid = 1'b0;
        #1;
        check({tag, "_stall_n1"}, stall, 1'b1);
        tick();
        #1;
        check({tag, "_valid"}, load_valid, 1'b1);
        check({tag, "_data"}, load_data, exp);
        check({tag, "_stall_n2"}, stall, 1'b0);
        tick();
    endtask

    initial begin
        rst_n          = 1'b0;
        flush          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_load_valid", load_valid, 1'b0);
        check("rst_load_data", load_data, 32'h0);
        check("rst_misaligned", misaligned, 1'b0);
        check("rst_access_fault", access_fault, 1'b0);
        check("rst_ready", bus.req_ready, 1'b1);
        check("rst_mem_en", bus.mem_en, 1'b0);
        rst_n = 1'b1;
        tick();

        drive(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        #1;
        check("sw_mem_en", bus.mem_en, 1'b1);
        check("sw_we", bus.mem_we, 4'hF);
        check("sw_addr", bus.mem_addr, 6'd4);
        check("sw_wdata", bus.mem_wdata, 32'hDEADBEEF);
        check("sw_stall", stall, 1'b0);
        tick();
        bus.req_valid = 1'b0;
        #1;
        check("sw_word4", mem_model[4], 32'hDEADBEEF);

        drive(1'b1, 3'b000, 32'h13, 32'h000000A5);
        #1;
        check("sb_we", bus.mem_we, 4'b1000);
        check("sb_wdata", bus.mem_wdata, 32'hA5A5A5A5);
        tick();
        drive(1'b0, 3'b000, 32'h13, 32'd0);
        #1;
        check("lb_mem_en", bus.mem_en, 1'b1);
        check("lb_we", bus.mem_we, 4'b0000);
        check("lb_stall_n", stall, 1'b1);
        tick();
        #1;
        check("lb_stall_n1", stall, 1'b1);
        check("lb_ready_n1", bus.req_ready, 1'b0);
        check("lb_held_no_access", bus.mem_en, 1'b0);
        check("lb_no_valid_n1", load_valid, 1'b0);
        tick();
        bus.req_valid = 1'b0;
        #1;
        check("lb_valid", load_valid, 1'b1);
        check("lb_data", load_data, 32'hFFFFFFA5);
        check("lb_stall_n2", stall, 1'b0);
        tick();
        check("lb_pulse_end", load_valid, 1'b0);
        check("sb_word4", mem_model[4], 32'hA5ADBEEF);

        store(3'b010, 32'h10, 32'h80017F00);
        load_check("lhu", 3'b101, 32'h12, 32'h00008001);
        load_check("lh", 3'b001, 32'h12, 32'hFFFF8001);
        load_check("lbu_lane1", 3'b100, 32'h11, 32'h0000007F);

        drive(1'b0, 3'b010, 32'h06, 32'd0);
        #1;
        check("mis_mem_en", bus.mem_en, 1'b0);
        check("mis_stall", stall, 1'b0);
        tick();
        bus.req_valid = 1'b0;
        #1;
        check("mis_flag", misaligned, 1'b1);
        check("mis_no_fault", access_fault, 1'b0);
        check("mis_ready", bus.req_ready, 1'b1);
        tick();
        check("mis_pulse_end", misaligned, 1'b0);

        drive(1'b0, 3'b010, 32'h100, 32'd0);
        #1;
        check("oor_mem_en", bus.mem_en, 1'b0);
        tick();
        bus.req_valid = 1'b0;
        #1;
        check("oor_fault", access_fault, 1'b1);
        check("oor_no_mis", misaligned, 1'b0);

        drive(1'b1, 3'b100, 32'h11, 32'h0);
        #1;
        check("ill_mem_en", bus.mem_en, 1'b0);
        tick();
        bus.req_valid = 1'b0;
        #1;
        check("ill_fault", access_fault, 1'b1);
        check("ill_no_mis", misaligned, 1'b0);

        drive(1'b0, 3'b010, 32'h06, 32'd0);
        flush = 1'b1;
        #1;
        check("fidle_mem_en", bus.mem_en, 1'b0);
        tick();
        bus.req_valid = 1'b0;
        flush = 1'b0;
        #1;
        check("fidle_no_mis", misaligned, 1'b0);
        check("fidle_no_fault", access_fault, 1'b0);

        store(3'b010, 32'h08, 32'h12345678);
        drive(1'b0, 3'b010, 32'h08, 32'd0);
        #1;
        check("fl_stall_n", stall, 1'b1);
        tick();
        bus.req_valid = 1'b0;
        flush = 1'b1;
        #1;
        check("fl_stall_drop", stall, 1'b0);
        tick();
        flush = 1'b0;
        #1;
        check("fl_no_valid", load_valid, 1'b0);
        check("fl_data_kept", load_data, 32'h0000007F);
        check("fl_ready", bus.req_ready, 1'b1);
        load_check("lw_after_flush", 3'b010, 32'h08, 32'h12345678);

        drive(1'b1, 3'b001, 32'h0A, 32'h0000BEEF);
        #1;
        check("sh_we", bus.mem_we, 4'b1100);
        check("sh_wdata", bus.mem_wdata, 32'hBEEFBEEF);
        tick();
        bus.req_valid = 1'b0;
        load_check("lhu_hi", 3'b101, 32'h0A, 32'h0000BEEF);
        load_check("lbu_lane3", 3'b100, 32'h0B, 32'h000000BE);

        drive(1'b0, 3'b010, 32'h10, 32'd0);
        tick();
        bus.req_valid = 1'b0;
        #1;
        check("rmid_stall_before", stall, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rmid_stall", stall, 1'b0);
        check("rmid_ready", bus.req_ready, 1'b1);
        check("rmid_data", load_data, 32'h0);
        check("rmid_valid", load_valid, 1'b0);
        tick();
        check("rmid_valid_held", load_valid, 1'b0);
        check("rmid_mem_en", bus.mem_en, 1'b0);
        rst_n = 1'b1;
        tick();
        load_check("lw_after_reset", 3'b010, 32'h10, 32'h80017F00);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
